// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and segment pattern constants for the seg7 receive path
//
// Purpose: FSM state type, widths, and the seven-segment pattern table used by
// seg7_pattern_decode and seg7_frame_decoder. Pattern bit i is segment i
// (a = bit 0 .. g = bit 6).
// Ports: none (package).
package seg7_pkg;

  localparam int SEG_W     = 7;
  localparam int BIT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SEG_W-1:0] SEG_DIGIT_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_DIGIT_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_DIGIT_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_DIGIT_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_DIGIT_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_DIGIT_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_DIGIT_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_DIGIT_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_DIGIT_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_DIGIT_9 = 7'h6F;

  // Alternate forms: 6 without segment a, 7 with segment f, 9 without segment d.
  localparam logic [SEG_W-1:0] SEG_ALT_6 = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_ALT_7 = 7'h27;
  localparam logic [SEG_W-1:0] SEG_ALT_9 = 7'h67;

  // Value reported for a pattern that is not in the table.
  localparam logic [3:0] DIGIT_BAD = 4'hF;

endpackage

// File: rtl/seg7_frame_decoder_if.sv
// rtl/seg7_frame_decoder_if.sv - pin-level bundle between a segment source and the frame decoder
//
// Purpose: groups the TinyTapeout user pins other than clk/rst.
// Pin map: io_in[2]=sdata, io_in[3]=sstrobe, io_in[4]=sync, io_in[5]=mode,
//          io_out[3:0]=disp, io_out[4]=frame_valid, io_out[5]=have_data,
//          io_out[6]=err, io_out[7]=busy. io_in[7:6] are not connected.
// Modports: master = segment source / checker side, slave = decoder side.
interface seg7_frame_decoder_if;

  logic       sdata;
  logic       sstrobe;
  logic       sync;
  logic       mode;
  logic [3:0] disp;
  logic       frame_valid;
  logic       have_data;
  logic       err;
  logic       busy;

  modport master (
    output sdata, sstrobe, sync, mode,
    input  disp, frame_valid, have_data, err, busy
  );

  modport slave (
    input  sdata, sstrobe, sync, mode,
    output disp, frame_valid, have_data, err, busy
  );

endinterface

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational seven-segment pattern to digit lookup
//
// Purpose: maps a 7-bit segment pattern back to its digit value.
// Ports:
//   pattern - segment pattern, bit i = segment i (a..g)
//   strict  - 1: canonical patterns only; 0: also the alternate 6/7/9 forms
//   digit   - decoded value, DIGIT_BAD when not recognised
//   hit     - pattern was recognised
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  input  logic             strict,
  output logic [3:0]       digit,
  output logic             hit
);

  always_comb begin
    digit = DIGIT_BAD;
    hit   = 1'b0;
    case (pattern)
      SEG_DIGIT_0: begin digit = 4'd0; hit = 1'b1; end
      SEG_DIGIT_1: begin digit = 4'd1; hit = 1'b1; end
      SEG_DIGIT_2: begin digit = 4'd2; hit = 1'b1; end
      SEG_DIGIT_3: begin digit = 4'd3; hit = 1'b1; end
      SEG_DIGIT_4: begin digit = 4'd4; hit = 1'b1; end
      SEG_DIGIT_5: begin digit = 4'd5; hit = 1'b1; end
      SEG_DIGIT_6: begin digit = 4'd6; hit = 1'b1; end
      SEG_DIGIT_7: begin digit = 4'd7; hit = 1'b1; end
      SEG_DIGIT_8: begin digit = 4'd8; hit = 1'b1; end
      SEG_DIGIT_9: begin digit = 4'd9; hit = 1'b1; end
      SEG_ALT_6: begin
        if (!strict) begin
          digit = 4'd6;
          hit   = 1'b1;
        end
      end
      SEG_ALT_7: begin
        if (!strict) begin
          digit = 4'd7;
          hit   = 1'b1;
        end
      end
      SEG_ALT_9: begin
        if (!strict) begin
          digit = 4'd9;
          hit   = 1'b1;
        end
      end
      default: begin
        digit = DIGIT_BAD;
        hit   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_frame_decoder.sv
// rtl/seg7_frame_decoder.sv - serial seven-segment frame receiver and digit decoder
//
// Purpose: shifts in segments a..g after a sync, decodes the pattern, flags
// unrecognised frames and keeps a saturating error count.
// Parameters:
//   ERR_CNT_W - error counter width; its low 4 bits are shown in mode 1
//   STRICT    - 1: canonical patterns only; 0: also alternate 6/7/9 forms
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - pin bundle (slave side): sdata/sstrobe/sync/mode in,
//         disp/frame_valid/have_data/err/busy out
module seg7_frame_decoder
  import seg7_pkg::*;
#(
  parameter int ERR_CNT_W = 4,
  parameter bit STRICT    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  seg7_frame_decoder_if.slave  bus
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(SEG_W - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

  state_t                 state_q, state_d;
  logic [SEG_W-1:0]       shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]             value_q, value_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic                   err_q, err_d;
  logic                   have_data_q, have_data_d;
  logic                   frame_valid_q, frame_valid_d;
  logic [3:0]             disp_q, disp_d;
  logic                   busy_q, busy_d;
  logic [3:0]             err_low;

  logic [3:0]             dec_digit;
  logic                   dec_hit;

  seg7_pattern_decode u_decode (
    .pattern (shreg_q),
    .strict  (STRICT),
    .digit   (dec_digit),
    .hit     (dec_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      value_q       <= '0;
      err_cnt_q     <= '0;
      err_q         <= 1'b0;
      have_data_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      disp_q        <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      value_q       <= value_d;
      err_cnt_q     <= err_cnt_d;
      err_q         <= err_d;
      have_data_q   <= have_data_d;
      frame_valid_q <= frame_valid_d;
      disp_q        <= disp_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    value_d       = value_q;
    err_cnt_d     = err_cnt_q;
    err_d         = err_q;
    have_data_d   = have_data_q;
    frame_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.sync) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end
      end

      SHIFT: begin
        // sync restarts the frame and takes priority over a coincident strobe.
        if (bus.sync) begin
          bit_cnt_d = '0;
        end else if (bus.sstrobe) begin
          shreg_d[bit_cnt_q] = bus.sdata;
          bit_cnt_d          = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        frame_valid_d = 1'b1;
        if (dec_hit) begin
          value_d     = dec_digit;
          err_d       = 1'b0;
          have_data_d = 1'b1;
        end else begin
          value_d = DIGIT_BAD;
          err_d   = 1'b1;
          if (err_cnt_q != ERR_MAX) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
        end
        // sync here starts the next frame without passing through IDLE.
        if (bus.sync) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // disp follows the post-update value/count so a completed frame shows on the same edge.
  generate
    if (ERR_CNT_W >= 4) begin : g_err_wide
      assign err_low = err_cnt_d[3:0];
    end else begin : g_err_narrow
      assign err_low = {{(4 - ERR_CNT_W){1'b0}}, err_cnt_d};
    end
  endgenerate

  always_comb begin
    disp_d = bus.mode ? err_low : value_d;
    busy_d = (state_d != IDLE);
  end

  assign bus.disp        = disp_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.have_data   = have_data_q;
  assign bus.err         = err_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// tb/tb_seg7_frame_decoder.sv - scoreboard bench for seg7_frame_decoder (strict and lax instances)
module tb_seg7_frame_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seg7_frame_decoder_if if_s ();
  seg7_frame_decoder_if if_l ();

  assign if_l.sdata   = if_s.sdata;
  assign if_l.sstrobe = if_s.sstrobe;
  assign if_l.sync    = if_s.sync;
  assign if_l.mode    = if_s.mode;

  seg7_frame_decoder #(.ERR_CNT_W(4), .STRICT(1'b1)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (if_s.slave)
  );

  seg7_frame_decoder #(.ERR_CNT_W(4), .STRICT(1'b0)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (if_l.slave)
  );

  typedef struct {
    logic [3:0] disp;
    logic       err;
    logic       have_data;
  } exp_t;

  exp_t q_s[$];
  exp_t q_l[$];
  int   checks   = 0;
  int   errors   = 0;
  int   pulses_s = 0;
  int   pulses_l = 0;
  bit   chk_busy = 1'b0;
  int   m_cnt[2];
  bit   m_have[2];

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Returns {hit, digit}.
  function automatic logic [4:0] model_decode(input logic [6:0] p, input bit strict);
    logic [6:0] tbl[10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    for (int i = 0; i < 10; i++) begin
      if (tbl[i] == p) return {1'b1, 4'(i)};
    end
    if (!strict) begin
      if (p == 7'h7C) return {1'b1, 4'd6};
      if (p == 7'h27) return {1'b1, 4'd7};
      if (p == 7'h67) return {1'b1, 4'd9};
    end
    return {1'b0, 4'hF};
  endfunction

  task automatic expect_frame(input logic [6:0] p);
    logic [4:0] r;
    logic [3:0] val;
    exp_t       e;
    for (int k = 0; k < 2; k++) begin
      r = model_decode(p, (k == 0));
      if (r[4]) begin
        val       = r[3:0];
        m_have[k] = 1'b1;
      end else begin
        val = 4'hF;
        if (m_cnt[k] < 15) m_cnt[k]++;
      end
      e.err       = ~r[4];
      e.have_data = m_have[k];
      e.disp      = if_s.mode ? 4'(m_cnt[k]) : val;
      if (k == 0) q_s.push_back(e);
      else        q_l.push_back(e);
    end
  endtask

  task automatic send_frame(input logic [6:0] p, input bit strobe_on_sync = 1'b0);
    if_s.sync    = 1'b1;
    if_s.sstrobe = strobe_on_sync;
    if_s.sdata   = strobe_on_sync;
    @(negedge clk);
    if_s.sync = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if_s.sstrobe = 1'b1;
      if_s.sdata   = p[i];
      @(negedge clk);
    end
    if_s.sstrobe = 1'b0;
    if_s.sdata   = 1'b0;
    expect_frame(p);
  endtask

  function automatic int outs(input logic [3:0] d, input logic fv, input logic hd,
                              input logic er, input logic bz);
    return int'({bz, er, hd, fv, d});
  endfunction

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (if_s.frame_valid === 1'b1) begin
      pulses_s++;
      if (q_s.size() == 0) chk("s_unexpected_pulse", 1, 0);
      else begin
        e = q_s.pop_front();
        chk("s_disp", int'(if_s.disp), int'(e.disp));
        chk("s_err", int'(if_s.err), int'(e.err));
        chk("s_have_data", int'(if_s.have_data), int'(e.have_data));
      end
    end
    if (if_l.frame_valid === 1'b1) begin
      pulses_l++;
      if (q_l.size() == 0) chk("l_unexpected_pulse", 1, 0);
      else begin
        e = q_l.pop_front();
        chk("l_disp", int'(if_l.disp), int'(e.disp));
        chk("l_err", int'(if_l.err), int'(e.err));
        chk("l_have_data", int'(if_l.have_data), int'(e.have_data));
      end
    end
    if (chk_busy) chk("busy_b2b", int'(if_s.busy), 1);
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int p0;
    if_s.sdata   = 1'b0;
    if_s.sstrobe = 1'b0;
    if_s.sync    = 1'b0;
    if_s.mode    = 1'b0;
    m_cnt        = '{0, 0};
    m_have       = '{1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_outs", outs(if_s.disp, if_s.frame_valid, if_s.have_data, if_s.err, if_s.busy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", outs(if_s.disp, if_s.frame_valid, if_s.have_data, if_s.err, if_s.busy), 0);

    // Strobe without sync in IDLE does nothing.
    if_s.sstrobe = 1'b1;
    if_s.sdata   = 1'b1;
    @(negedge clk);
    if_s.sstrobe = 1'b0;
    if_s.sdata   = 1'b0;
    @(negedge clk);
    chk("idle_strobe_busy", int'(if_s.busy), 0);
    chk("idle_strobe_fv", int'(if_s.frame_valid), 0);

    // Digit 8, then check pulse width and hold.
    send_frame(7'h7F);
    chk("fv_before_done", int'(if_s.frame_valid), 0);
    @(negedge clk);
    chk("fv_pulse", int'(if_s.frame_valid), 1);
    @(negedge clk);
    chk("fv_clear", int'(if_s.frame_valid), 0);
    chk("busy_idle", int'(if_s.busy), 0);
    chk("hold_disp", int'(if_s.disp), 8);

    // Bad pattern 0x49, then mode 1 shows the count one edge later.
    send_frame(7'h49);
    repeat (2) @(negedge clk);
    if_s.mode = 1'b1;
    chk("mode_not_yet", int'(if_s.disp), 15);
    @(posedge clk);
    #1;
    chk("mode1_disp", int'(if_s.disp), 1);
    @(negedge clk);

    // 20 back-to-back bad frames, sync asserted in DONE.
    p0 = pulses_s;
    send_frame(7'h00);
    chk_busy = 1'b1;
    repeat (19) send_frame(7'h00);
    chk_busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("sat_disp", int'(if_s.disp), 15);
    chk("sat_pulses", pulses_s - p0, 20);
    chk("sat_busy_drop", int'(if_s.busy), 0);
    if_s.mode = 1'b0;
    @(negedge clk);
    chk("mode0_disp", int'(if_s.disp), 15);

    // Abort after 4 bits; restart sync carries a strobe that must be dropped.
    p0 = pulses_s;
    if_s.sync = 1'b1;
    @(negedge clk);
    if_s.sync = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if_s.sstrobe = 1'b1;
      if_s.sdata   = 1'b1;
      @(negedge clk);
    end
    send_frame(7'h06, 1'b1);
    repeat (2) @(negedge clk);
    chk("abort_pulses", pulses_s - p0, 1);
    chk("abort_disp", int'(if_s.disp), 1);

    // Alternate 6 form.
    send_frame(7'h7C);
    repeat (2) @(negedge clk);
    chk("strict_alt6_err", int'(if_s.err), 1);
    chk("lax_alt6_err", int'(if_l.err), 0);
    chk("lax_alt6_disp", int'(if_l.disp), 6);

    // Asynchronous reset in the middle of a frame.
    if_s.sync = 1'b1;
    @(negedge clk);
    if_s.sync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if_s.sstrobe = 1'b1;
      if_s.sdata   = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_s", outs(if_s.disp, if_s.frame_valid, if_s.have_data, if_s.err, if_s.busy), 0);
    chk("async_rst_l", outs(if_l.disp, if_l.frame_valid, if_l.have_data, if_l.err, if_l.busy), 0);
    if_s.sstrobe = 1'b0;
    if_s.sdata   = 1'b0;
    m_cnt        = '{0, 0};
    m_have       = '{1'b0, 1'b0};
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    send_frame(7'h7D);
    repeat (2) @(negedge clk);
    chk("post_rst_disp", int'(if_s.disp), 6);
    chk("post_rst_have", int'(if_s.have_data), 1);
    if_s.mode = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_errcnt", int'(if_s.disp), 0);
    @(negedge clk);

    chk("q_s_empty", q_s.size(), 0);
    chk("q_l_empty", q_l.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_frame_decoder.md
Name: seg7_frame_decoder

Overview:
Receive-side counterpart of the popcount seven-segment display driver. It captures a serially shifted seven-segment pattern, bits a..g, and maps it back to a 4-bit digit value. It flags unrecognised patterns and keeps a saturating error count. It sits as a TinyTapeout user module on the 8-in/8-out pin interface, so a second tile or a bench can check display traffic.

Parameters:
ERR_CNT_W, 4, width of the saturating error counter; its low 4 bits are shown in mode 1.
STRICT, 1, 1 = accept only the canonical patterns; 0 = also accept the alternate 6 (0x7C), 7 (0x27) and 9 (0x67) forms.

Ports:
io_in[0]  input  1  clk, the single clock; all state updates on its rising edge.
io_in[1]  input  1  rst, asynchronous, active-high reset.
io_in[2]  input  1  sdata, serial segment bit; segment a first, g last.
io_in[3]  input  1  sstrobe, sdata is valid this cycle.
io_in[4]  input  1  sync, frame start; also aborts and restarts a frame in progress.
io_in[5]  input  1  mode; 0 = show the decoded value, 1 = show the error count.
io_in[7:6]  input  2  unused, ignored.
io_out[3:0]  output  4  disp, the last decoded value (mode 0) or err_cnt[3:0] (mode 1).
io_out[4]  output  1  frame_valid, one-cycle pulse per completed frame.
io_out[5]  output  1  have_data, sticky; set by the first good frame.
io_out[6]  output  1  err, the last completed frame was unrecognised.
io_out[7]  output  1  busy, high while in SHIFT or DONE.

Behaviour:
- Pattern bit i is segment i (a=bit0 .. g=bit6).
- Canonical table: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
- Reset, asynchronous: state=IDLE, shreg=0, bit_cnt=0, value=0, err_cnt=0. All io_out bits are 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - sync=1 -> SHIFT, bit_cnt=0.
  - sstrobe without sync is ignored.
- SHIFT:
  - sstrobe=1 -> shreg[bit_cnt] <= sdata, bit_cnt++.
  - Strobe with bit_cnt==6 -> DONE; the pattern is complete.
  - sync=1 -> bit_cnt=0 and stay in SHIFT; the partial frame is discarded with no pulse and no error.
  - sync and sstrobe in the same cycle: sync wins and the strobe bit is dropped.
- DONE, exactly one cycle:
  - Decode shreg and register the result.
  - Good pattern: value <= digit, err <= 0, have_data <= 1.
  - Bad pattern: value <= 4'hF, err <= 1, err_cnt++ saturating at all-ones.
  - frame_valid <= 1 for exactly one cycle.
  - Next state: sync=1 -> SHIFT with bit_cnt=0 (back-to-back frames); otherwise IDLE.
  - sstrobe in DONE is ignored.
- Latency: 7th strobe sampled at edge k -> disp, err and frame_valid updated at edge k+1. frame_valid clears at edge k+2.
- disp is a registered mux of value and err_cnt[3:0], updated every cycle from mode. A mode change is visible one edge later.
- busy = (state != IDLE), registered alongside state.
- value, err and have_data hold between frames. Only reset clears have_data.
- Reset mid-frame: the partial frame is lost with no pulse, and err_cnt is cleared.
- err_cnt saturation: it stays at max; it does not wrap.

Decomposition:
- Package seg7_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - SEG_DIGIT_0..9 pattern constants and the alternate-form constants;
  - SEG_W=7 and BIT_CNT_W=3.
- Sub-module seg7_pattern_decode, combinational: 7-bit pattern plus STRICT in; 4-bit digit and hit out. It is shared with any later display-checking tiles.
- Top holds the FSM, shift register, counters and output registers.

Test Plan:
- Frame for digit 8: sync, then strobes with sdata a..g=1,1,1,1,1,1,1 -> frame_valid pulse one edge after the 7th strobe; disp=8, err=0, have_data=1.
- Pattern 0x49 (a,d,g lit): -> disp=F, err=1, err_cnt=1; with mode=1, disp=1 one edge later.
- 20 bad frames back-to-back, with sync asserted in DONE -> err_cnt saturates and disp stays F in mode 1; frame_valid pulses 20 times; busy never drops between frames.
- Abort: sync, 4 strobes, sync, then a full 0x06 frame -> exactly one frame_valid pulse, disp=1; sync+strobe in the same cycle drops that bit.
- Reset asserted asynchronously mid-SHIFT -> all outputs 0 immediately; the next full 0x7D frame decodes to 6.
- STRICT=0: pattern 0x7C decodes to 6 with err=0; under STRICT=1 the same pattern gives err=1.
